// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result bundle between the datapath and the ALU execution unit
//
// Purpose : groups the start/ready/done handshake, operands and the registered
//           result/flags of alu_exec_unit into one interface.
// Signals : start, alu_opcode, op_a, op_b        driven by the datapath (master)
//           ready, busy, done, result, carry,    driven by the unit (slave)
//           zero, take_branch
interface alu_exec_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             ready;
   logic [2:0]       alu_opcode;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             take_branch;
   logic             done;
   logic             busy;

   modport master (
      output start, alu_opcode, op_a, op_b,
      input  ready, busy, done, result, carry, zero, take_branch
   );

   modport slave (
      input  start, alu_opcode, op_a, op_b,
      output ready, busy, done, result, carry, zero, take_branch
   );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - sequential ALU: single-cycle logic/arithmetic, bit-serial shifts
//
// Purpose : executes one alu_opcode per accepted request. Add/sub/logic/compare
//           complete at the accept edge; shifts move one bit per clock.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - alu_exec_unit_if.slave (handshake, operands, result, flags)
module alu_exec_unit #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic           clk,
   input  logic           reset,
   alu_exec_unit_if.slave bus
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_CNE = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic             accept;
   logic             is_shift;
   logic             shift_start;
   logic [SHW-1:0]   amount;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_branch;

   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_shifted;
   logic [SHW-1:0]   count_q;
   logic             dir_left_q;
   logic             shift_out;
   logic             last_shift;

   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic             branch_q;
   logic             done_q;

   assign accept      = bus.start && (state_q == S_IDLE);
   assign amount      = bus.op_b[SHW-1:0];
   assign is_shift    = (bus.alu_opcode == OP_SHL) || (bus.alu_opcode == OP_SHR);
   // Shift by zero takes the single-cycle path and simply returns op_a.
   assign shift_start = accept && is_shift && (amount != '0);

   // One extra bit on each side: the MSB is the carry-out for add and the
   // borrow (a < b unsigned) for sub.
   assign sum_ext  = {1'b0, bus.op_a} + {1'b0, bus.op_b};
   assign diff_ext = {1'b0, bus.op_a} - {1'b0, bus.op_b};

   always_comb begin
      alu_result = bus.op_a;
      alu_carry  = 1'b0;
      alu_branch = 1'b0;
      case (bus.alu_opcode)
         OP_ADD: begin
            alu_result = sum_ext[WIDTH-1:0];
            alu_carry  = sum_ext[WIDTH];
         end
         OP_SUB: begin
            alu_result = diff_ext[WIDTH-1:0];
            alu_carry  = diff_ext[WIDTH];
         end
         OP_AND: alu_result = bus.op_a & bus.op_b;
         OP_OR:  alu_result = bus.op_a | bus.op_b;
         OP_XOR: alu_result = bus.op_a ^ bus.op_b;
         OP_CNE: begin
            alu_result = bus.op_a ^ bus.op_b;
            alu_branch = (bus.op_a != bus.op_b);
         end
         default: begin
            // Shifts reaching here have amount 0: result = op_a, carry = 0.
            alu_result = bus.op_a;
         end
      endcase
   end

   // Working register for the bit-serial shifter.
   assign work_shifted = dir_left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
   assign shift_out    = dir_left_q ? work_q[WIDTH-1] : work_q[0];
   assign last_shift   = (count_q == SHW'(1));

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (shift_start) state_d = S_SHIFT;
         S_SHIFT: if (last_shift)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.ready = (state_q == S_IDLE);
      bus.busy  = (state_q != S_IDLE);
   end

   // Datapath and registered results. Visible outputs are only written on a
   // completion edge; intermediate shift bits stay in work_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_q     <= '0;
         count_q    <= '0;
         dir_left_q <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b1;
         branch_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (shift_start) begin
                  work_q     <= bus.op_a;
                  count_q    <= amount;
                  dir_left_q <= (bus.alu_opcode == OP_SHL);
               end else if (accept) begin
                  result_q <= alu_result;
                  carry_q  <= alu_carry;
                  zero_q   <= (alu_result == '0);
                  branch_q <= alu_branch;
                  done_q   <= 1'b1;
               end
            end
            S_SHIFT: begin
               work_q  <= work_shifted;
               count_q <= count_q - SHW'(1);
               if (last_shift) begin
                  result_q <= work_shifted;
                  carry_q  <= shift_out;
                  zero_q   <= (work_shifted == '0);
                  branch_q <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result      = result_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;
   assign bus.take_branch = branch_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
   localparam int WIDTH = 8;
   localparam int SHW   = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

   alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: the arithmetic meaning of each opcode.
   function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic c, output logic t,
                                 output int shift_cycles);
      int         n;
      logic [8:0] wide;
      n = int'(b) % 8;
      r = 8'h00; c = 1'b0; t = 1'b0; shift_cycles = 0; wide = 9'h000;
      case (op)
         3'd0: begin wide = 9'(a) + 9'(b); r = wide[7:0]; c = wide[8]; end
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = a << n; c = (n > 0) ? a[8-n] : 1'b0; shift_cycles = n; end
         3'd6: begin r = a ^ b; t = (a != b); end
         default: begin r = a >> n; c = (n > 0) ? a[n-1] : 1'b0; shift_cycles = n; end
      endcase
   endfunction

   // Drive one request, scramble inputs after accept, wait for done.
   // Returns at the falling edge where done is seen high.
   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      bus.start = 1'b1; bus.alu_opcode = op; bus.op_a = a; bus.op_b = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.alu_opcode = 3'($urandom); bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
      lat = 1; busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.ready === 1'b0) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b required 1 (op=%0d a=%h b=%h)", bus.done, op, a, b);
      end
   endtask

   task automatic test_reset();
      int lat, bc;
      run_op(3'd6, 8'h01, 8'h02, lat, bc);
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h required 00", bus.result); end
      checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b required 1", bus.zero); end
      checks++; if (bus.carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b required 0", bus.carry); end
      checks++; if (bus.take_branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b required 0", bus.take_branch); end
      checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ready: ready=%b busy=%b required 1/0", bus.ready, bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_arith_back_to_back();
      @(negedge clk);
      bus.start = 1'b1; bus.alu_opcode = 3'd0; bus.op_a = 8'hF0; bus.op_b = 8'h20;
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.result !== 8'h10 || bus.carry !== 1'b1 || bus.zero !== 1'b0)
         begin errors++; $display("FAIL add_f0_20: done=%b result=%h carry=%b zero=%b required 1/10/1/0", bus.done, bus.result, bus.carry, bus.zero); end
      bus.alu_opcode = 3'd1; bus.op_a = 8'h05; bus.op_b = 8'h07;
      @(negedge clk);
      checks++; if (bus.done !== 1'b1 || bus.result !== 8'hFE || bus.carry !== 1'b1 || bus.zero !== 1'b0)
         begin errors++; $display("FAIL sub_05_07: done=%b result=%h carry=%b zero=%b required 1/fe/1/0", bus.done, bus.result, bus.carry, bus.zero); end
      bus.op_a = 8'h07; bus.op_b = 8'h07;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1 || bus.result !== 8'h00 || bus.carry !== 1'b0 || bus.zero !== 1'b1)
         begin errors++; $display("FAIL sub_07_07: done=%b result=%h carry=%b zero=%b required 1/00/0/1", bus.done, bus.result, bus.carry, bus.zero); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: done=%b required 0", bus.done); end
   endtask

   task automatic test_compare();
      int lat, bc;
      run_op(3'd6, 8'h3C, 8'h3C, lat, bc);
      checks++; if (bus.take_branch !== 1'b0 || bus.zero !== 1'b1 || bus.carry !== 1'b0)
         begin errors++; $display("FAIL cne_equal: branch=%b zero=%b carry=%b required 0/1/0", bus.take_branch, bus.zero, bus.carry); end
      run_op(3'd6, 8'h3C, 8'h3D, lat, bc);
      checks++; if (bus.take_branch !== 1'b1 || bus.result !== 8'h01 || bus.zero !== 1'b0)
         begin errors++; $display("FAIL cne_differ: branch=%b result=%h zero=%b required 1/01/0", bus.take_branch, bus.result, bus.zero); end
   endtask

   task automatic test_shift();
      int lat, bc;
      run_op(3'd5, 8'h81, 8'h03, lat, bc);
      checks++; if (bc !== 3 || lat !== 4) begin errors++; $display("FAIL shl3_timing: busy=%0d lat=%0d required 3/4", bc, lat); end
      checks++; if (bus.result !== 8'h08 || bus.carry !== 1'b0 || bus.ready !== 1'b1)
         begin errors++; $display("FAIL shl3_value: result=%h carry=%b ready=%b required 08/0/1", bus.result, bus.carry, bus.ready); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL shl3_single_done: done=%b required 0", bus.done); end
      run_op(3'd7, 8'h81, 8'h01, lat, bc);
      checks++; if (bus.result !== 8'h40 || bus.carry !== 1'b1 || bc !== 1)
         begin errors++; $display("FAIL shr1: result=%h carry=%b busy=%0d required 40/1/1", bus.result, bus.carry, bc); end
      run_op(3'd5, 8'h81, 8'h00, lat, bc);
      checks++; if (bus.result !== 8'h81 || bus.carry !== 1'b0 || lat !== 1 || bc !== 0)
         begin errors++; $display("FAIL shl0: result=%h carry=%b lat=%0d busy=%0d required 81/0/1/0", bus.result, bus.carry, lat, bc); end
   endtask

   task automatic test_ignore_busy();
      int dones, done_at;
      logic [7:0] r_at_done;
      logic       c_at_done;
      dones = 0; done_at = -1; r_at_done = 8'h00; c_at_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_opcode = 3'd7; bus.op_a = 8'hFF; bus.op_b = 8'h07;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin dones++; done_at = k; r_at_done = bus.result; c_at_done = bus.carry; end
         if (k == 2) begin
            bus.start = 1'b1; bus.alu_opcode = 3'd0; bus.op_a = 8'h01; bus.op_b = 8'h01;
         end else begin
            bus.start = 1'b0;
         end
      end
      checks++; if (dones !== 1 || done_at !== 8) begin errors++; $display("FAIL busy_done_count: dones=%0d at=%0d required 1 at 8", dones, done_at); end
      checks++; if (r_at_done !== 8'h01 || c_at_done !== 1'b1) begin errors++; $display("FAIL shr7_value: result=%h carry=%b required 01/1", r_at_done, c_at_done); end
      checks++; if (bus.result !== 8'h01) begin errors++; $display("FAIL busy_add_ignored: result=%h required 01", bus.result); end
   endtask

   task automatic test_reset_mid_shift();
      int dones;
      dones = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_opcode = 3'd5; bus.op_a = 8'h01; bus.op_b = 8'h06;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_shift_busy: ready=%b required 0", bus.ready); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.result !== 8'h00 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.zero !== 1'b1)
         begin errors++; $display("FAIL mid_shift_reset: result=%h ready=%b done=%b zero=%b required 00/1/0/1", bus.result, bus.ready, bus.done, bus.zero); end
      @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b1; bus.alu_opcode = 3'd0; bus.op_a = 8'h01; bus.op_b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1 || bus.result !== 8'h02 || bus.carry !== 1'b0)
         begin errors++; $display("FAIL post_reset_add: done=%b result=%h carry=%b required 1/02/0", bus.done, bus.result, bus.carry); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      checks++; if (dones !== 0 || bus.result !== 8'h02) begin errors++; $display("FAIL aborted_shift_silent: dones=%0d result=%h required 0/02", dones, bus.result); end
   endtask

   task automatic test_random();
      int lat, bc, exp_cyc;
      logic [2:0] op;
      logic [7:0] a, b, er;
      logic ec, et;
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         if (i % 4 == 0) b = a;
         model(op, a, b, er, ec, et, exp_cyc);
         run_op(op, a, b, lat, bc);
         checks++;
         if (bus.result !== er || bus.carry !== ec || bus.zero !== (er == 8'h00) || bus.take_branch !== et)
            begin errors++; $display("FAIL rand_value op=%0d a=%h b=%h: result=%h carry=%b zero=%b br=%b required %h/%b/%b/%b",
                                     op, a, b, bus.result, bus.carry, bus.zero, bus.take_branch, er, ec, (er == 8'h00), et); end
         checks++;
         if (bc !== exp_cyc || lat !== exp_cyc + 1)
            begin errors++; $display("FAIL rand_timing op=%0d b=%h: busy=%0d lat=%0d required %0d/%0d", op, b, bc, lat, exp_cyc, exp_cyc + 1); end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.alu_opcode = 3'd0; bus.op_a = 8'h00; bus.op_b = 8'h00;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_arith_back_to_back();
      test_compare();
      test_shift();
      test_ignore_busy();
      test_reset_mid_shift();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential ALU execution unit that consumes the 3-bit `alu_opcode` produced by the ALU control decode. It executes one operation per accepted request on two WIDTH-bit operands. Logic/arithmetic ops complete in one cycle; shifts iterate one bit per cycle. The unit returns a registered result, flags and a branch-take bit to the datapath through a start/ready/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width.
- `SHW`, default 3: shift-amount width; must equal log2(WIDTH).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request valid; accepted only when `ready`=1.
- `ready` out 1: unit can accept a request this cycle.
- `alu_opcode` in 3: operation select, sampled at accept.
- `op_a` in WIDTH: first operand, sampled at accept.
- `op_b` in WIDTH: second operand; for shifts, `op_b[SHW-1:0]` is the amount. Sampled at accept.
- `result` out WIDTH: registered result, held until the next completion.
- `carry` out 1: registered carry/borrow/shift-out flag.
- `zero` out 1: registered, equals (`result`==0).
- `take_branch` out 1: registered; 1 only after an opcode 110 completion with `op_a`!=`op_b`.
- `done` out 1: one-cycle pulse in the cycle after the completing edge.
- `busy` out 1: equals !`ready`.

## Operation
- Opcode map:
  - 000: add; `result`=a+b mod 2^WIDTH; `carry`=carry-out.
  - 001: sub; `result`=a−b mod 2^WIDTH; `carry`=1 iff a<b unsigned (borrow).
  - 010: and.
  - 011: or.
  - 100: xor.
  - 101: logical shift left.
  - 110: compare-not-equal; `result`=a^b.
  - 111: logical shift right.
- `carry`=0 for 010, 011, 100 and 110.
- `take_branch`=0 for every opcode other than 110.
- FSM states:
  - IDLE: `ready`=1.
  - SHIFT: `ready`=0.
- IDLE, accept of a non-shift op, or of a shift with amount 0: compute at the accept edge, load `result` and flags, pulse `done`, stay in IDLE.
  - Shift by 0: `result`=a, `carry`=0.
- IDLE, accept of a shift with amount n>0: load the working register with a, load the counter with n, go to SHIFT.
- SHIFT: each edge shifts the working register one bit and zero-fills. `carry` captures the bit shifted out: MSB for shl, LSB for shr. The counter decrements.
  - On the edge where the counter goes 1→0, load `result`, `zero` and `take_branch`=0, pulse `done`, return to IDLE.
- `start` while `ready`=0 is ignored; no queueing.
- Outputs `result`, `carry`, `zero` and `take_branch` change only on completion edges or reset.
- Reset values:
  - `result`=0, `carry`=0, `take_branch`=0, `done`=0.
  - `zero`=1 (consistent with `result`=0).
  - State IDLE, so `ready`=1 and `busy`=0.

## Timing
- Accept edge = rising edge with `start`=1 and `ready`=1.
- Non-shift op, or shift by 0: completes at the accept edge E0. `done`=1 during cycle E0→E1.
- Shift by n≥1: completes at edge En. `done`=1 during cycle En→En+1. `ready`=0 from E0 to En, and `ready`=1 again in the same cycle `done` is high.
- Back-to-back: a new request may be accepted in the cycle `done` is high. Single-cycle ops sustain one accept and one `done` per cycle.
- Reset mid-SHIFT:
  - The operation aborts and no `done` is produced.
  - Outputs go to reset values asynchronously.
  - The first accept is possible on the first edge after `reset` deasserts.
- Operand or opcode changes after accept have no effect on the operation in flight.

## Test plan
- Reset: assert `reset` mid-cycle, WIDTH=8 → `result`=0, `zero`=1, `carry`=0, `ready`=1, `done`=0 without a clock edge.
- Arithmetic, one accept per cycle:
  - add 0xF0+0x20 → `result`=0x10, `carry`=1, `zero`=0.
  - sub 0x05−0x07 → `result`=0xFE, `carry`=1.
  - sub 0x07−0x07 → `result`=0x00, `zero`=1, `carry`=0.
  - Each produces a `done` pulse in consecutive cycles.
- Compare: opcode 110 with a=0x3C, b=0x3C → `take_branch`=0, `zero`=1. Then a=0x3C, b=0x3D → `take_branch`=1, `result`=0x01.
- Shift, multi-cycle:
  - shl a=0x81, b=3: `ready`=0 for exactly 3 cycles, then `result`=0x08, `carry`=0, single `done` pulse.
  - shr a=0x81, b=1: `result`=0x40, `carry`=1.
  - shl by 0 → `result`=0x81 with 1-cycle latency.
- Ignore while busy: start shr a=0xFF, b=7, then pulse `start` with add during SHIFT → add is not executed, `result`=0x01 after 7 cycles, exactly one `done`.
- Reset mid-shift: start shl a=0x01, b=6, assert `reset` after 2 cycles → no `done`, `result`=0. The next add 0x01+0x01 → `result`=0x02.
